edge_event_arbiter: RTL and testbench

Collects one-cycle edge pulses from up to NUM_CH edge-detector instances, timestamps each event against a free-running counter, and serialises the events onto a single valid/ready event stream using round-robin arbitration. It sits between the per-pin edge detectors and the HIL capture/logging path, so that one consumer can service all monitored signals. Lost events are reported per event and through sticky per-channel flags.

---
 rtl/edge_event_arbiter.sv | 133 +++++++++++++
 tb/tb_edge_event_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_arbiter.sv
// Timestamps one-cycle edge pulses from NUM_CH channels and serialises them onto a single
// valid/ready event stream with round-robin arbitration and per-channel overrun tracking.
module edge_event_arbiter #(
  parameter int unsigned  NUM_CH   = 4,
  parameter int unsigned  TS_WIDTH = 16,
  localparam int unsigned CH_W     = $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_CH-1:0]   edge_pulse,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [CH_W-1:0]     evt_channel,
  output logic [TS_WIDTH-1:0] evt_timestamp,
  output logic                evt_missed,
  output logic [NUM_CH-1:0]   overrun_flags,
  input  logic                clear_overrun
);

  logic [TS_WIDTH-1:0] ts_cnt_q, ts_cnt_d;
  logic [NUM_CH-1:0]   pending_q, pending_d;
  logic [NUM_CH-1:0]   missed_q, missed_d;
  logic [NUM_CH-1:0]   overrun_q, overrun_d;
  logic [TS_WIDTH-1:0] ts_cap_q [NUM_CH];
  logic [TS_WIDTH-1:0] ts_cap_d [NUM_CH];
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic                evt_valid_q, evt_valid_d;
  logic [CH_W-1:0]     evt_channel_q, evt_channel_d;
  logic [TS_WIDTH-1:0] evt_timestamp_q, evt_timestamp_d;
  logic                evt_missed_q, evt_missed_d;

  logic                load_ok;
  logic                gnt_found;
  logic [CH_W-1:0]     gnt_idx;
  logic [CH_W-1:0]     scan_idx;
  logic [NUM_CH-1:0]   gnt_vec;

  assign load_ok  = !evt_valid_q || evt_ready;
  assign ts_cnt_d = ts_cnt_q + TS_WIDTH'(1);

  // First pending channel at or after rr_ptr, wrapping modulo NUM_CH.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      scan_idx = CH_W'((32'(rr_ptr_q) + k) % NUM_CH);
      if (!gnt_found && pending_q[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
    gnt_vec = (load_ok && gnt_found) ? (NUM_CH'(1) << gnt_idx) : '0;
  end

  // A pulse on the channel being granted re-arms it rather than counting as a drop.
  always_comb begin
    pending_d = pending_q;
    missed_d  = missed_q;
    ts_cap_d  = ts_cap_q;
    overrun_d = clear_overrun ? '0 : overrun_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (gnt_vec[i]) begin
        pending_d[i] = 1'b0;
        missed_d[i]  = 1'b0;
      end
      if (enable && edge_pulse[i]) begin
        if (!pending_q[i] || gnt_vec[i]) begin
          pending_d[i] = 1'b1;
          ts_cap_d[i]  = ts_cnt_q;
          missed_d[i]  = 1'b0;
        end else begin
          missed_d[i]  = 1'b1;
          overrun_d[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    evt_valid_d     = evt_valid_q;
    evt_channel_d   = evt_channel_q;
    evt_timestamp_d = evt_timestamp_q;
    evt_missed_d    = evt_missed_q;
    rr_ptr_d        = rr_ptr_q;
    if (load_ok) begin
      evt_valid_d = gnt_found;
      if (gnt_found) begin
        evt_channel_d   = gnt_idx;
        evt_timestamp_d = ts_cap_q[gnt_idx];
        evt_missed_d    = missed_q[gnt_idx];
        rr_ptr_d        = CH_W'((32'(gnt_idx) + 32'd1) % NUM_CH);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_cnt_q        <= '0;
      pending_q       <= '0;
      missed_q        <= '0;
      overrun_q       <= '0;
      rr_ptr_q        <= '0;
      evt_valid_q     <= 1'b0;
      evt_channel_q   <= '0;
      evt_timestamp_q <= '0;
      evt_missed_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        ts_cap_q[i] <= '0;
      end
    end else begin
      ts_cnt_q        <= ts_cnt_d;
      pending_q       <= pending_d;
      missed_q        <= missed_d;
      overrun_q       <= overrun_d;
      rr_ptr_q        <= rr_ptr_d;
      evt_valid_q     <= evt_valid_d;
      evt_channel_q   <= evt_channel_d;
      evt_timestamp_q <= evt_timestamp_d;
      evt_missed_q    <= evt_missed_d;
      ts_cap_q        <= ts_cap_d;
    end
  end

  assign evt_valid     = evt_valid_q;
  assign evt_channel   = evt_channel_q;
  assign evt_timestamp = evt_timestamp_q;
  assign evt_missed    = evt_missed_q;
  assign overrun_flags = overrun_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios with literal expectations plus a long
// randomized run checked every cycle against a behavioural model of the event queue.
module tb_edge_event_arbiter;

  localparam int N   = 4;
  localparam int TSW = 16;

  logic           clk;
  logic           reset;
  logic           enable;
  logic [N-1:0]   edge_pulse;
  logic           evt_valid;
  logic           evt_ready;
  logic [1:0]     evt_channel;
  logic [TSW-1:0] evt_timestamp;
  logic           evt_missed;
  logic [N-1:0]   overrun_flags;
  logic           clear_overrun;

  edge_event_arbiter #(
    .NUM_CH  (N),
    .TS_WIDTH(TSW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .edge_pulse   (edge_pulse),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_channel  (evt_channel),
    .evt_timestamp(evt_timestamp),
    .evt_missed   (evt_missed),
    .overrun_flags(overrun_flags),
    .clear_overrun(clear_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: per-channel pending slots and a one-entry output holding register.
  bit       m_pend [N];
  bit       m_miss [N];
  int       m_cap  [N];
  int       m_ts, m_rr, m_ch, m_tso, g, c;
  bit       m_valid, m_mo, lok;
  bit [N-1:0] m_ovr;

  always @(posedge clk) begin
    if (reset) begin
      m_ts = 0; m_rr = 0; m_valid = 0; m_ch = 0; m_tso = 0; m_mo = 0; m_ovr = '0;
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_miss[i] = 0; m_cap[i] = 0;
      end
    end else begin
      lok = !m_valid || evt_ready;
      g = -1;
      if (lok) begin
        for (int k = 0; k < N; k++) begin
          c = (m_rr + k) % N;
          if (g < 0 && m_pend[c]) g = c;
        end
        if (g >= 0) begin
          m_valid = 1; m_ch = g; m_tso = m_cap[g]; m_mo = m_miss[g];
          m_pend[g] = 0; m_rr = (g + 1) % N;
        end else begin
          m_valid = 0;
        end
      end
      if (clear_overrun) m_ovr = '0;
      if (enable) begin
        for (int i = 0; i < N; i++) begin
          if (edge_pulse[i]) begin
            if (!m_pend[i]) begin
              m_pend[i] = 1; m_cap[i] = m_ts; m_miss[i] = 0;
            end else begin
              m_miss[i] = 1; m_ovr[i] = 1;
            end
          end
        end
      end
      m_ts = (m_ts + 1) % (1 << TSW);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_valid", 32'(evt_valid), 32'(m_valid));
      chk("cmp_channel", 32'(evt_channel), m_ch);
      chk("cmp_timestamp", 32'(evt_timestamp), m_tso);
      chk("cmp_missed", 32'(evt_missed), 32'(m_mo));
      chk("cmp_overrun", 32'(overrun_flags), 32'(m_ovr));
    end
  end

  // cyc tracks the counter value of the cycle we are in after the edge.
  task automatic tick();
    @(posedge clk);
    cyc = reset ? 0 : cyc + 1;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; edge_pulse = '0; clear_overrun = 1'b0; evt_ready = 1'b1;
    tick();
    reset  = 1'b0;
    cmp_en = 1'b1;
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_channel", 32'(evt_channel), 0);
    chk("rst_timestamp", 32'(evt_timestamp), 0);
    chk("rst_missed", 32'(evt_missed), 0);
    chk("rst_overrun", 32'(overrun_flags), 0);
  endtask

  task automatic pulse_at(input int at, input logic [N-1:0] p);
    while (cyc < at) tick();
    edge_pulse = p;
    tick();
    edge_pulse = '0;
  endtask

  task automatic chk_evt(input string name, input int ch, input int ts, input int ms);
    chk({name, "_valid"}, 32'(evt_valid), 1);
    chk({name, "_channel"}, 32'(evt_channel), ch);
    chk({name, "_timestamp"}, 32'(evt_timestamp), ts);
    chk({name, "_missed"}, 32'(evt_missed), ms);
  endtask

  int order [N];

  initial begin
    reset = 1'b1; enable = 1'b1; edge_pulse = '0; clear_overrun = 1'b0; evt_ready = 1'b1;

    // Single pulse
    do_reset();
    pulse_at(10, 4'b0010);
    chk("single_c11_valid", 32'(evt_valid), 0);
    tick();
    chk_evt("single_c12", 1, 10, 0);
    tick();
    chk("single_c13_valid", 32'(evt_valid), 0);

    // Simultaneous pulses, round robin from 0 then from 2
    do_reset();
    pulse_at(3, 4'b1111);
    chk("rr0_c4_valid", 32'(evt_valid), 0);
    for (int k = 0; k < N; k++) begin
      tick();
      chk_evt("rr0", k, 3, 0);
    end
    tick();
    chk("rr0_end_valid", 32'(evt_valid), 0);
    pulse_at(12, 4'b0010);
    tick();
    chk_evt("rr_setup", 1, 12, 0);
    order[0] = 2; order[1] = 3; order[2] = 0; order[3] = 1;
    pulse_at(16, 4'b1111);
    for (int k = 0; k < N; k++) begin
      tick();
      chk_evt("rr2", order[k], 16, 0);
    end

    // Backpressure
    do_reset();
    evt_ready = 1'b0;
    pulse_at(2, 4'b0101);
    tick();
    for (int k = 0; k < 20; k++) begin
      chk_evt("bp_hold", 0, 2, 0);
      tick();
    end
    chk_evt("bp_hold_end", 0, 2, 0);
    evt_ready = 1'b1;
    tick();
    chk_evt("bp_second", 2, 2, 0);
    tick();
    chk("bp_drained", 32'(evt_valid), 0);

    // Overrun, then clear racing a new overrun
    do_reset();
    evt_ready = 1'b0;
    pulse_at(2, 4'b0001);
    pulse_at(5, 4'b1000);
    pulse_at(8, 4'b1000);
    chk("ovr_set", 32'(overrun_flags), 32'h8);
    chk_evt("ovr_head", 0, 2, 0);
    while (cyc < 12) tick();
    clear_overrun = 1'b1;
    edge_pulse    = 4'b1000;
    tick();
    clear_overrun = 1'b0;
    edge_pulse    = '0;
    chk("ovr_set_wins", 32'(overrun_flags), 32'h8);
    while (cyc < 14) tick();
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    chk("ovr_cleared", 32'(overrun_flags), 0);
    evt_ready = 1'b1;
    tick();
    chk_evt("ovr_evt", 3, 5, 1);
    tick();
    chk("ovr_drained", 32'(evt_valid), 0);

    // Re-arm during grant
    do_reset();
    pulse_at(3, 4'b0010);
    edge_pulse = 4'b0010;
    tick();
    edge_pulse = '0;
    chk_evt("rearm_first", 1, 3, 0);
    chk("rearm_ovr1", 32'(overrun_flags), 0);
    tick();
    chk_evt("rearm_second", 1, 4, 0);
    chk("rearm_ovr2", 32'(overrun_flags), 0);
    tick();
    chk("rearm_drained", 32'(evt_valid), 0);

    // Enable low drops pulses silently
    do_reset();
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      edge_pulse = 4'b1111;
      tick();
      chk("dis_valid", 32'(evt_valid), 0);
    end
    edge_pulse = '0;
    enable     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("dis_after_valid", 32'(evt_valid), 0);
      chk("dis_after_ovr", 32'(overrun_flags), 0);
    end

    // Reset mid-operation
    do_reset();
    evt_ready = 1'b0;
    pulse_at(2, 4'b1111);
    tick();
    chk("midrst_before", 32'(evt_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_valid", 32'(evt_valid), 0);
    evt_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("midrst_quiet", 32'(evt_valid), 0);
    end

    // Randomized run leading up to the counter wrap
    do_reset();
    while (cyc < 65400) begin
      edge_pulse    = N'($urandom_range(0, 15) & $urandom_range(0, 15));
      enable        = ($urandom_range(0, 9) != 0);
      evt_ready     = ($urandom_range(0, 3) != 0);
      clear_overrun = ($urandom_range(0, 31) == 0);
      tick();
    end
    edge_pulse = '0; enable = 1'b1; evt_ready = 1'b1; clear_overrun = 1'b1;
    while (cyc < 65535) tick();
    clear_overrun = 1'b0;
    edge_pulse = 4'b0001;
    tick();
    edge_pulse = 4'b0100;
    tick();
    edge_pulse = '0;
    chk_evt("wrap_ffff", 0, 16'hFFFF, 0);
    tick();
    chk_evt("wrap_0000", 2, 0, 0);
    tick();
    chk("wrap_drained", 32'(evt_valid), 0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
